// File: rtl/multi_edge_detector.sv
// Multi-channel input conditioner: per-channel synchroniser, stability filter,
// mode-selected rise/fall edge pulse and sticky W1C pending flag.
module multi_edge_detector #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter logic        RESET_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   line_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   clr_i,
  output logic [NUM_CH-1:0]   level_o,
  output logic [NUM_CH-1:0]   edge_o,
  output logic [NUM_CH-1:0]   pending_o,
  output logic                any_edge_o
);

  localparam int unsigned    CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_CH-1:0][CW-1:0]          cnt_q;
  logic [NUM_CH-1:0]                  prev_q;
  logic [NUM_CH-1:0]                  s;

  always_comb begin
    s = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= {(NUM_CH*SYNC_STAGES){RESET_LEVEL}};
      cnt_q     <= '0;
      level_o   <= {NUM_CH{RESET_LEVEL}};
      prev_q    <= {NUM_CH{RESET_LEVEL}};
      edge_o    <= '0;
      pending_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // An X/Z pad value makes both compares unknown, so stage 1 keeps its value.
        if ((line_i[i] == 1'b0) || (line_i[i] == 1'b1)) begin
          sync_q[i][0] <= line_i[i];
        end
        sync_q[i][SYNC_STAGES-1:1] <= sync_q[i][SYNC_STAGES-2:0];

        if (s[i] == level_o[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          level_o[i] <= s[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end

        prev_q[i]    <= level_o[i];
        edge_o[i]    <= (level_o[i] & ~prev_q[i] & mode_i[2*i]) |
                        (~level_o[i] & prev_q[i] & mode_i[2*i+1]);
        // A new edge takes priority over a same-cycle clear.
        pending_o[i] <= edge_o[i] | (pending_o[i] & ~clr_i[i]);
      end
    end
  end

  assign any_edge_o = |edge_o;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: directed scenarios with fixed
// expectations plus a randomized run against a history-based reference model.
module tb_multi_edge_detector;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILTER_LEN  = 3;
  localparam logic        RESET_LEVEL = 1'b1;

  logic       clk;
  logic       rst;
  logic [3:0] line;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] level;
  logic [3:0] edges;
  logic [3:0] pending;
  logic       any_edge;

  int errors = 0;
  int checks = 0;

  multi_edge_detector #(
    .NUM_CH(NUM_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN(FILTER_LEN),
    .RESET_LEVEL(RESET_LEVEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .line_i(line),
    .mode_i(mode),
    .clr_i(clr),
    .level_o(level),
    .edge_o(edges),
    .pending_o(pending),
    .any_edge_o(any_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a sample history delayed by the synchroniser depth, and a
  // level that flips once the last FILTER_LEN delayed samples all disagree with it.
  logic [3:0] m_level, m_prev, m_edge, m_pend;
  logic       samp_q[4][$];
  logic       win_q[4][$];

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        samp_q[c] = {};
        win_q[c]  = {};
        for (int k = 0; k < SYNC_STAGES; k++) samp_q[c].push_back(RESET_LEVEL);
      end
      m_level = {4{RESET_LEVEL}};
      m_prev  = {4{RESET_LEVEL}};
      m_edge  = '0;
      m_pend  = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        logic sv, nw, all_diff;
        m_pend[c] = m_edge[c] ? 1'b1 : (clr[c] ? 1'b0 : m_pend[c]);
        m_edge[c] = ((m_level[c] != m_prev[c]) && m_level[c]  && mode[2*c]) ||
                    ((m_level[c] != m_prev[c]) && !m_level[c] && mode[2*c+1]);
        m_prev[c] = m_level[c];
        sv = samp_q[c].pop_front();
        nw = $isunknown(line[c]) ? samp_q[c][$] : line[c];
        samp_q[c].push_back(nw);
        win_q[c].push_back(sv);
        if (win_q[c].size() > FILTER_LEN) void'(win_q[c].pop_front());
        all_diff = (win_q[c].size() == FILTER_LEN);
        foreach (win_q[c][k]) if (win_q[c][k] == m_level[c]) all_diff = 1'b0;
        if (all_diff) m_level[c] = ~m_level[c];
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; line = 4'hF; mode = 8'h55; clr = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({level, edges, pending, any_edge} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got level=%h edge=%h pend=%h any=%b, want F 0 0 0",
               level, edges, pending, any_edge);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({level, edges, pending, any_edge} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold cyc%0d: got level=%h edge=%h pend=%h any=%b, want F 0 0 0",
                 i, level, edges, pending, any_edge);
      end
    end
    line = 4'h0;
    repeat (6) @(negedge clk);
    checks++;
    if (level !== 4'h0) begin
      errors++;
      $display("FAIL pre_reset_level: got %h want 0", level);
    end
    rst = 1'b1; line = 4'hF;
    #1;
    checks++;
    if ({level, edges, pending, any_edge} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: got level=%h edge=%h pend=%h any=%b, want F 0 0 0",
               level, edges, pending, any_edge);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({level, edges, pending} !== {4'hF, 4'h0, 4'h0}) begin
        errors++;
        $display("FAIL post_release cyc%0d: got level=%h edge=%h pend=%h, want F 0 0",
                 i, level, edges, pending);
      end
    end
  endtask

  task automatic test_rise_latency();
    mode = 8'h01;
    line[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (edges[0] !== 1'b0) begin
        errors++;
        $display("FAIL masked_fall cyc%0d: got edge0=%b want 0", i, edges[0]);
      end
    end
    checks++;
    if (level[0] !== 1'b0) begin
      errors++;
      $display("FAIL fall_level: got level0=%b want 0", level[0]);
    end
    line[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++;
      if ({level[0], edges[0], pending[0]} !== {1'(j >= 4), 1'(j == 5), 1'(j >= 6)}) begin
        errors++;
        $display("FAIL rise_latency k+%0d: got lvl/edge/pend=%b%b%b want %b%b%b", j,
                 level[0], edges[0], pending[0], 1'(j >= 4), 1'(j == 5), 1'(j >= 6));
      end
    end
    clr = 4'hF;
    @(negedge clk);
    clr = 4'h0;
  endtask

  task automatic test_glitch();
    int falls, rises;
    logic saw_low;
    mode = 8'h0C;
    line[1] = 1'b0;
    repeat (2) @(negedge clk);
    line[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({level[1], edges[1]} !== 2'b10) begin
        errors++;
        $display("FAIL glitch_reject cyc%0d: got level1=%b edge1=%b want 1 0",
                 i, level[1], edges[1]);
      end
    end
    falls = 0; rises = 0; saw_low = 1'b0;
    line[1] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (level[1] === 1'b0) saw_low = 1'b1;
      if (edges[1] === 1'b1 && level[1] === 1'b0) falls++;
      if (edges[1] === 1'b1 && level[1] === 1'b1) rises++;
      if (i == 2) line[1] = 1'b1;
    end
    checks++;
    if (falls != 1 || rises != 1 || !saw_low) begin
      errors++;
      $display("FAIL min_pulse: got falls=%0d rises=%0d low=%b want 1 1 1", falls, rises, saw_low);
    end
    clr = 4'hF;
    @(negedge clk);
    clr = 4'h0;
  endtask

  task automatic test_modes();
    int cnt[4];
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    mode = 8'hE4;
    for (int i = 0; i < 74; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (edges[c] === 1'b1) cnt[c]++;
      checks++;
      if (!(level === 4'h0 || level === 4'hF) || any_edge !== |edges) begin
        errors++;
        $display("FAIL modes_cycle %0d: got level=%h any=%b edge=%h, want uniform level and any=|edge",
                 i, level, any_edge, edges);
      end
      line = (i < 64 && (i % 16) < 8) ? 4'h0 : 4'hF;
    end
    checks++;
    if (cnt[0] != 0 || cnt[1] != 4 || cnt[2] != 4 || cnt[3] != 8) begin
      errors++;
      $display("FAIL mode_counts: got %0d %0d %0d %0d want 0 4 4 8", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    checks++;
    if (pending !== 4'hE) begin
      errors++;
      $display("FAIL modes_pending: got %h want e", pending);
    end
  endtask

  task automatic test_pending();
    bit found;
    clr = 4'b0100;
    @(negedge clk);
    clr = 4'h0;
    @(negedge clk);
    checks++;
    if (pending !== 4'hA) begin
      errors++;
      $display("FAIL single_clear: got %h want a", pending);
    end
    line[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (edges[2] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ch2_edge_timeout: got no edge within 20 cycles want pulse");
    end
    clr = 4'b0100;
    @(negedge clk);
    checks++;
    if ({pending[2], edges[2]} !== 2'b10) begin
      errors++;
      $display("FAIL set_wins: got pend2=%b edge2=%b want 1 0", pending[2], edges[2]);
    end
    @(negedge clk);
    checks++;
    if (pending !== 4'hA) begin
      errors++;
      $display("FAIL delayed_clear: got %h want a", pending);
    end
    clr = 4'b0001;
    @(negedge clk);
    clr = 4'h0;
    checks++;
    if (pending !== 4'hA) begin
      errors++;
      $display("FAIL clear_noop: got %h want a", pending);
    end
    line[2] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_xz_random();
    line = 4'hF; mode = 8'hFF;
    repeat (10) @(negedge clk);
    clr = 4'hF;
    @(negedge clk);
    clr = 4'h0;
    line[3] = 1'bx;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) line[3] = 1'bz;
      @(negedge clk);
      if ($isunknown(line[3])) begin
        checks++;
        if ({level[3], edges[3]} !== 2'b10) begin
          errors++;
          $display("FAIL xz_hold cyc%0d: got level3=%b edge3=%b want 1 0", i, level[3], edges[3]);
        end
      end
    end
    line[3] = 1'b1;
    for (int i = 0; i < 10010; i++) begin
      @(negedge clk);
      checks++;
      if ({level, edges, pending, any_edge} !== {m_level, m_edge, m_pend, |m_edge}) begin
        errors++;
        $display("FAIL model cyc%0d: got lvl=%h edge=%h pend=%h any=%b want %h %h %h %b", i,
                 level, edges, pending, any_edge, m_level, m_edge, m_pend, |m_edge);
      end
      if (i >= 10) begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(4, 0) == 0) line[c] = ~line[c];
          clr[c] = ($urandom_range(7, 0) == 0);
        end
        if (i % 500 == 0) mode = 8'($urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_modes();
    test_pending();
    test_xz_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
